// File: rtl/instr_encoder_pkg.sv
// Shared RV32IM/Zicsr encoding tables: symbolic ops, major opcodes,
// funct fields and encoder error codes.
package instr_encoder_pkg;

  typedef enum logic [6:0] {
    EN_LUI, EN_AUIPC, EN_JAL, EN_JALR,
    EN_BEQ, EN_BNE, EN_BLT, EN_BGE, EN_BLTU, EN_BGEU,
    EN_LB, EN_LH, EN_LW, EN_LBU, EN_LHU,
    EN_SB, EN_SH, EN_SW,
    EN_ADDI, EN_SLTI, EN_SLTIU, EN_XORI, EN_ORI, EN_ANDI,
    EN_SLLI, EN_SRLI, EN_SRAI,
    EN_ADD, EN_SUB, EN_SLL, EN_SLT, EN_SLTU,
    EN_XOR, EN_SRL, EN_SRA, EN_OR, EN_AND,
    EN_MUL, EN_MULH, EN_MULHSU, EN_MULHU,
    EN_DIV, EN_DIVU, EN_REM, EN_REMU,
    EN_CSRRW, EN_CSRRS, EN_CSRRC,
    EN_CSRRWI, EN_CSRRSI, EN_CSRRCI,
    EN_FENCE, EN_FENCE_I, EN_ECALL, EN_EBREAK, EN_MRET
  } enc_op_e;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [31:0] W_FENCE   = 32'h0FF0_000F;
  localparam logic [31:0] W_FENCE_I = 32'h0000_100F;
  localparam logic [31:0] W_ECALL   = 32'h0000_0073;
  localparam logic [31:0] W_EBREAK  = 32'h0010_0073;
  localparam logic [31:0] W_MRET    = 32'h3020_0073;

  typedef enum logic [1:0] {
    ERR_NONE, ERR_ILLEGAL, ERR_RANGE, ERR_ALIGN
  } enc_err_e;

  typedef enum logic [3:0] {
    FMT_X, FMT_R, FMT_I, FMT_SH, FMT_S,
    FMT_B, FMT_U, FMT_J, FMT_CSR, FMT_FIX
  } enc_fmt_e;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: symbolic instruction to RV32 word
// plus immediate legality check.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] raw,
  output enc_err_e    err_code
);

  enc_fmt_e    fmt;
  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] fix;
  logic [31:0] word;
  enc_err_e    err;
  logic        i_ok, b_ok, j_ok;

  always_comb begin
    fmt = FMT_X;
    opc = '0;
    f7  = F7_BASE;
    f3  = '0;
    fix = '0;
    case (op)
      EN_LUI:    begin fmt = FMT_U; opc = OP_LUI; end
      EN_AUIPC:  begin fmt = FMT_U; opc = OP_AUIPC; end
      EN_JAL:    begin fmt = FMT_J; opc = OP_JAL; end
      EN_JALR:   begin fmt = FMT_I; opc = OP_JALR; end
      EN_BEQ:    begin fmt = FMT_B; opc = OP_BRANCH; f3 = 3'b000; end
      EN_BNE:    begin fmt = FMT_B; opc = OP_BRANCH; f3 = 3'b001; end
      EN_BLT:    begin fmt = FMT_B; opc = OP_BRANCH; f3 = 3'b100; end
      EN_BGE:    begin fmt = FMT_B; opc = OP_BRANCH; f3 = 3'b101; end
      EN_BLTU:   begin fmt = FMT_B; opc = OP_BRANCH; f3 = 3'b110; end
      EN_BGEU:   begin fmt = FMT_B; opc = OP_BRANCH; f3 = 3'b111; end
      EN_LB:     begin fmt = FMT_I; opc = OP_LOAD; f3 = 3'b000; end
      EN_LH:     begin fmt = FMT_I; opc = OP_LOAD; f3 = 3'b001; end
      EN_LW:     begin fmt = FMT_I; opc = OP_LOAD; f3 = 3'b010; end
      EN_LBU:    begin fmt = FMT_I; opc = OP_LOAD; f3 = 3'b100; end
      EN_LHU:    begin fmt = FMT_I; opc = OP_LOAD; f3 = 3'b101; end
      EN_SB:     begin fmt = FMT_S; opc = OP_STORE; f3 = 3'b000; end
      EN_SH:     begin fmt = FMT_S; opc = OP_STORE; f3 = 3'b001; end
      EN_SW:     begin fmt = FMT_S; opc = OP_STORE; f3 = 3'b010; end
      EN_ADDI:   begin fmt = FMT_I; opc = OP_IMM; f3 = F3_ADD; end
      EN_SLTI:   begin fmt = FMT_I; opc = OP_IMM; f3 = F3_SLT; end
      EN_SLTIU:  begin fmt = FMT_I; opc = OP_IMM; f3 = F3_SLTU; end
      EN_XORI:   begin fmt = FMT_I; opc = OP_IMM; f3 = F3_XOR; end
      EN_ORI:    begin fmt = FMT_I; opc = OP_IMM; f3 = F3_OR; end
      EN_ANDI:   begin fmt = FMT_I; opc = OP_IMM; f3 = F3_AND; end
      EN_SLLI:   begin fmt = FMT_SH; opc = OP_IMM; f3 = F3_SLL; end
      EN_SRLI:   begin fmt = FMT_SH; opc = OP_IMM; f3 = F3_SR; end
      EN_SRAI:   begin fmt = FMT_SH; opc = OP_IMM; f3 = F3_SR; f7 = F7_ALT; end
      EN_ADD:    begin fmt = FMT_R; opc = OP_REG; f3 = F3_ADD; end
      EN_SUB:    begin fmt = FMT_R; opc = OP_REG; f3 = F3_ADD; f7 = F7_ALT; end
      EN_SLL:    begin fmt = FMT_R; opc = OP_REG; f3 = F3_SLL; end
      EN_SLT:    begin fmt = FMT_R; opc = OP_REG; f3 = F3_SLT; end
      EN_SLTU:   begin fmt = FMT_R; opc = OP_REG; f3 = F3_SLTU; end
      EN_XOR:    begin fmt = FMT_R; opc = OP_REG; f3 = F3_XOR; end
      EN_SRL:    begin fmt = FMT_R; opc = OP_REG; f3 = F3_SR; end
      EN_SRA:    begin fmt = FMT_R; opc = OP_REG; f3 = F3_SR; f7 = F7_ALT; end
      EN_OR:     begin fmt = FMT_R; opc = OP_REG; f3 = F3_OR; end
      EN_AND:    begin fmt = FMT_R; opc = OP_REG; f3 = F3_AND; end
      EN_MUL:    begin fmt = FMT_R; opc = OP_REG; f3 = 3'b000; f7 = F7_MULDIV; end
      EN_MULH:   begin fmt = FMT_R; opc = OP_REG; f3 = 3'b001; f7 = F7_MULDIV; end
      EN_MULHSU: begin fmt = FMT_R; opc = OP_REG; f3 = 3'b010; f7 = F7_MULDIV; end
      EN_MULHU:  begin fmt = FMT_R; opc = OP_REG; f3 = 3'b011; f7 = F7_MULDIV; end
      EN_DIV:    begin fmt = FMT_R; opc = OP_REG; f3 = 3'b100; f7 = F7_MULDIV; end
      EN_DIVU:   begin fmt = FMT_R; opc = OP_REG; f3 = 3'b101; f7 = F7_MULDIV; end
      EN_REM:    begin fmt = FMT_R; opc = OP_REG; f3 = 3'b110; f7 = F7_MULDIV; end
      EN_REMU:   begin fmt = FMT_R; opc = OP_REG; f3 = 3'b111; f7 = F7_MULDIV; end
      EN_CSRRW:  begin fmt = FMT_CSR; opc = OP_SYSTEM; f3 = 3'b001; end
      EN_CSRRS:  begin fmt = FMT_CSR; opc = OP_SYSTEM; f3 = 3'b010; end
      EN_CSRRC:  begin fmt = FMT_CSR; opc = OP_SYSTEM; f3 = 3'b011; end
      EN_CSRRWI: begin fmt = FMT_CSR; opc = OP_SYSTEM; f3 = 3'b101; end
      EN_CSRRSI: begin fmt = FMT_CSR; opc = OP_SYSTEM; f3 = 3'b110; end
      EN_CSRRCI: begin fmt = FMT_CSR; opc = OP_SYSTEM; f3 = 3'b111; end
      EN_FENCE:  begin fmt = FMT_FIX; fix = W_FENCE; end
      EN_FENCE_I: begin fmt = FMT_FIX; fix = W_FENCE_I; end
      EN_ECALL:  begin fmt = FMT_FIX; fix = W_ECALL; end
      EN_EBREAK: begin fmt = FMT_FIX; fix = W_EBREAK; end
      EN_MRET:   begin fmt = FMT_FIX; fix = W_MRET; end
      default:   fmt = FMT_X;
    endcase
  end

  // Sign-extension checks: every bit above the field's MSB must match it
  assign i_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_ok = (&imm[31:12]) | ~(|imm[31:12]);
  assign j_ok = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    word = '0;
    err  = ERR_NONE;
    case (fmt)
      FMT_R: word = {f7, rs2, rs1, f3, rd, opc};
      FMT_I: begin
        word = {imm[11:0], rs1, f3, rd, opc};
        if (!i_ok) err = ERR_RANGE;
      end
      FMT_SH: begin
        word = {f7, imm[4:0], rs1, f3, rd, opc};
        if (|imm[31:5]) err = ERR_RANGE;
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
        if (!i_ok) err = ERR_RANGE;
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, f3,
                imm[4:1], imm[11], opc};
        if (imm[0]) err = ERR_ALIGN;
        else if (!b_ok) err = ERR_RANGE;
      end
      FMT_U: begin
        word = {imm[31:12], rd, opc};
        if (|imm[11:0]) err = ERR_RANGE;
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
        if (imm[0]) err = ERR_ALIGN;
        else if (!j_ok) err = ERR_RANGE;
      end
      FMT_CSR: begin
        word = {imm[11:0], rs1, f3, rd, opc};
        if (|imm[31:12]) err = ERR_RANGE;
      end
      FMT_FIX: word = fix;
      default: err = ERR_ILLEGAL;
    endcase
  end

  assign raw      = (err == ERR_NONE) ? word : '0;
  assign err_code = err;

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready instruction encoder that tags each emitted
// word with its sequential instruction-memory address.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_raw,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [1:0]  out_err_code
);

  logic        s1_valid;
  logic [6:0]  s1_op;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [31:0] s1_imm;

  logic        s2_valid;
  logic [31:0] s2_raw;
  logic [31:0] s2_addr;
  enc_err_e    s2_code;

  logic [31:0] pk_raw;
  enc_err_e    pk_code;
  logic [31:0] cnt, cnt_next;
  logic        s2_free, in_fire, out_fire, mv;

  instr_pack u_pack (
    .op       (s1_op),
    .rd       (s1_rd),
    .rs1      (s1_rs1),
    .rs2      (s1_rs2),
    .imm      (s1_imm),
    .raw      (pk_raw),
    .err_code (pk_code)
  );

  assign s2_free  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid && out_ready;
  assign mv       = s1_valid && s2_free;

  // A word entering S2 can only have the S2 word ahead of it leaving
  // this cycle, so the post-update counter is exactly its address.
  always_comb begin
    cnt_next = cnt;
    if (clear)
      cnt_next = BASE_ADDR;
    else if (out_fire && s2_code == ERR_NONE)
      cnt_next = cnt + ADDR_STEP;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_rd    <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_imm   <= '0;
      s2_valid <= 1'b0;
      s2_raw   <= '0;
      s2_addr  <= BASE_ADDR;
      s2_code  <= ERR_NONE;
      cnt      <= BASE_ADDR;
    end else begin
      cnt <= cnt_next;
      if (clear) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (in_fire) s1_valid <= 1'b1;
        else if (mv) s1_valid <= 1'b0;
        if (mv) s2_valid <= 1'b1;
        else if (out_fire) s2_valid <= 1'b0;
      end
      if (in_fire && !clear) begin
        s1_op  <= in_op;
        s1_rd  <= in_rd;
        s1_rs1 <= in_rs1;
        s1_rs2 <= in_rs2;
        s1_imm <= in_imm;
      end
      if (mv && !clear) begin
        s2_raw  <= pk_raw;
        s2_code <= pk_code;
        s2_addr <= cnt_next;
      end
    end
  end

  assign out_valid    = s2_valid;
  assign out_raw      = s2_raw;
  assign out_addr     = s2_addr;
  assign out_err      = (s2_code != ERR_NONE);
  assign out_err_code = s2_code;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed scoreboard bench for instr_encoder: expected words are queued
// on input acceptance and checked when they leave the encoder.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_op = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_raw;
  logic [31:0] out_addr;
  logic        out_err;
  logic [1:0]  out_err_code;

  always #5 clk = ~clk;

  instr_encoder #(
    .BASE_ADDR (32'h0000_0000),
    .ADDR_STEP (32'd4)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_rd        (in_rd),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_imm       (in_imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_raw      (out_raw),
    .out_addr     (out_addr),
    .out_err      (out_err),
    .out_err_code (out_err_code)
  );

  typedef struct {
    logic [31:0] raw;
    logic [31:0] addr;
    logic [1:0]  code;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pop = 0;
  logic [31:0] m_addr = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_word", 32'(q.size()), 32'd1);
      end else begin
        mon_e = q.pop_front();
        n_pop++;
        chk("raw", out_raw, mon_e.raw);
        chk("addr", out_addr, mon_e.addr);
        chk("err", 32'(out_err), 32'(mon_e.code != 2'd0));
        chk("err_code", 32'(out_err_code), 32'(mon_e.code));
      end
    end
  end

  task automatic send(input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] raw,
                      input logic [1:0] code);
    bit   ok = 1'b0;
    exp_t e;
    in_valid = 1'b1;
    in_op  = op;
    in_rd  = rd;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_imm = imm;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        e.raw  = (code == 2'd0) ? raw : 32'h0;
        e.addr = m_addr;
        e.code = code;
        q.push_back(e);
        if (code == 2'd0) m_addr = m_addr + 32'd4;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("accepted", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] hold;
    time         t0;
    int          p0;

    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_raw", out_raw, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_code", 32'(out_err_code), 32'd0);

    send(EN_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 2'd0);
    chk("lat_s1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_s2", 32'(out_valid), 32'd1);
    drain();

    t0 = $time;
    send(EN_LUI, 5'd2, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_5137, 2'd0);
    send(EN_BEQ, 5'd0, 5'd1, 5'd2, -32'sd4, 32'hFE20_8EE3, 2'd0);
    send(EN_MUL, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0220_81B3, 2'd0);
    chk("b2b_time", 32'($time - t0), 32'd30);
    drain();

    send(EN_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0, 2'd2);
    send(EN_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 2'd0);
    send(EN_BEQ, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0, 2'd3);
    send(7'h7F, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0, 2'd1);
    send(EN_JAL, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0, 2'd3);
    send(EN_SLLI, 5'd1, 5'd1, 5'd0, 32'd32, 32'h0, 2'd2);
    send(EN_JAL, 5'd1, 5'd0, 5'd0, 32'd8, 32'h0080_00EF, 2'd0);
    send(EN_CSRRWI, 5'd0, 5'd5, 5'd0, 32'h305, 32'h3052_D073, 2'd0);
    drain();

    out_ready = 1'b0;
    p0 = n_pop;
    fork
      begin
        send(EN_SW, 5'd0, 5'd2, 5'd5, 32'd12, 32'h0051_2623, 2'd0);
        send(EN_SRAI, 5'd3, 5'd4, 5'd0, 32'd7, 32'h4072_5193, 2'd0);
        send(EN_ECALL, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_0073, 2'd0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_accepts", 32'(q.size()), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        hold = out_raw;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_stable", out_raw, hold);
        chk("bp_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_pops", 32'(n_pop - p0), 32'd3);

    out_ready = 1'b0;
    send(EN_ADDI, 5'd4, 5'd0, 5'd0, 32'd1, 32'h0010_0213, 2'd0);
    send(EN_ADDI, 5'd5, 5'd0, 5'd0, 32'd2, 32'h0020_0293, 2'd0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    q.delete();
    m_addr = 32'h0;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("clr_no_ghost", 32'(out_valid), 32'd0);
    send(EN_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 2'd0);
    drain();

    out_ready = 1'b0;
    send(EN_LUI, 5'd2, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_5137, 2'd0);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_raw", out_raw, 32'h0);
    rstn = 1'b1;
    q.delete();
    m_addr = 32'h0;
    out_ready = 1'b1;
    send(EN_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 2'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
